alu_sequencer: RTL and testbench

Initiator side of the ALU datapath interface. It accepts one operation request (op code, two operands, Y shift mode) over a valid/ready handshake. It then drives the shared bus, the Y operand (y_shifted) and ALU_control in a fixed two-cycle sequence, captures the ALU result into an internal Z register, and returns it over a valid/ready response handshake. It sits between instruction decode and the combinational alu, replacing hand-driven control words.

---
 rtl/alu_sequencer.sv | 163 ++++++++++++++++
 tb/tb_alu_sequencer.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// alu_sequencer: takes one ALU request over a valid/ready handshake, steps the
// shared bus, the Y register and ALU_control through LOAD_Y then EXEC, captures
// the ALU result in Z and returns it over a valid/ready response handshake.
// Optional status flags (rsp_zero, rsp_neg) are built when ALU_SEQ_STATUS_EN
// is defined.
module alu_sequencer #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [1:0]       req_shift,
  output logic [WIDTH-1:0] alu_bus,
  output logic [WIDTH-1:0] alu_y_shifted,
  output logic [2:0]       alu_control,
  input  logic [WIDTH-1:0] alu_result,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
`ifdef ALU_SEQ_STATUS_EN
  output logic             rsp_zero,
  output logic             rsp_neg,
`endif
  output logic             rsp_err
);

  typedef enum logic [1:0] {StIdle, StLoadY, StExec, StResp} state_e;

  state_e state_q, state_d;

  logic [2:0]       op_q;
  logic [WIDTH-1:0] b_q;
  logic [1:0]       shift_q;
  logic [WIDTH-1:0] bus_q;
  logic [2:0]       ctl_q;
  logic [WIDTH-1:0] y_q;
  logic [WIDTH-1:0] z_q;
  logic             err_q;
  logic [WIDTH-1:0] y_next;
  logic             req_fire;
  logic             req_illegal;

`ifdef ALU_SEQ_STATUS_EN
  logic zero_q;
  logic neg_q;
`endif

  assign req_fire    = req_valid && req_ready;
  assign req_illegal = (req_op == 3'b111) || (req_shift == 2'b11);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and the two handshake outputs decoded from state.
  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    unique case (state_q)
      StIdle: begin
        req_ready = 1'b1;
        if (req_valid) begin
          state_d = req_illegal ? StResp : StLoadY;
        end
      end
      StLoadY: state_d = StExec;
      StExec:  state_d = StResp;
      StResp: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Shifted operand A; during LOAD_Y the bus register already carries A.
  always_comb begin
    y_next = bus_q;
    unique case (shift_q)
      2'b01:   y_next = {bus_q[WIDTH-2:0], 1'b0};
      2'b10:   y_next = {1'b0, bus_q[WIDTH-1:1]};
      default: y_next = bus_q;
    endcase
  end

  // Datapath registers: request latch, bus/control drive, Y, Z and error.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_q    <= 3'b000;
      b_q     <= '0;
      shift_q <= 2'b00;
      bus_q   <= '0;
      ctl_q   <= 3'b000;
      y_q     <= '0;
      z_q     <= '0;
      err_q   <= 1'b0;
`ifdef ALU_SEQ_STATUS_EN
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        StIdle: begin
          if (req_fire) begin
            op_q    <= req_op;
            b_q     <= req_b;
            shift_q <= req_shift;
            if (req_illegal) begin
              z_q    <= '0;
              err_q  <= 1'b1;
`ifdef ALU_SEQ_STATUS_EN
              zero_q <= 1'b0;
              neg_q  <= 1'b0;
`endif
            end else begin
              bus_q <= req_a;
            end
          end
        end
        StLoadY: begin
          y_q   <= y_next;
          bus_q <= b_q;
          ctl_q <= op_q;
        end
        StExec: begin
          z_q    <= alu_result;
          err_q  <= 1'b0;
          bus_q  <= '0;
          ctl_q  <= 3'b000;
`ifdef ALU_SEQ_STATUS_EN
          zero_q <= (alu_result == '0);
          neg_q  <= alu_result[WIDTH-1];
`endif
        end
        default: begin
        end
      endcase
    end
  end

  assign alu_bus       = bus_q;
  assign alu_control   = ctl_q;
  assign alu_y_shifted = y_q;
  assign rsp_data      = z_q;
  assign rsp_err       = err_q;
`ifdef ALU_SEQ_STATUS_EN
  assign rsp_zero      = zero_q;
  assign rsp_neg       = neg_q;
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// Testbench for alu_sequencer: transaction-level model checked every cycle,
// plus directed requests with hand-computed literal expectations.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_op = 3'b000;
  logic [15:0] req_a = 16'h0;
  logic [15:0] req_b = 16'h0;
  logic [1:0]  req_shift = 2'b00;
  logic [15:0] alu_bus;
  logic [15:0] alu_y_shifted;
  logic [2:0]  alu_control;
  logic [15:0] alu_result;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [15:0] rsp_data;
  logic        rsp_err;
`ifdef ALU_SEQ_STATUS_EN
  logic        rsp_zero;
  logic        rsp_neg;
`endif

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  alu_sequencer #(.WIDTH(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_op       (req_op),
    .req_a        (req_a),
    .req_b        (req_b),
    .req_shift    (req_shift),
    .alu_bus      (alu_bus),
    .alu_y_shifted(alu_y_shifted),
    .alu_control  (alu_control),
    .alu_result   (alu_result),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_data     (rsp_data),
`ifdef ALU_SEQ_STATUS_EN
    .rsp_zero     (rsp_zero),
    .rsp_neg      (rsp_neg),
`endif
    .rsp_err      (rsp_err)
  );

  // Combinational ALU stub standing in for the real alu.
  function automatic logic [15:0] alu_f(input logic [2:0] op, input logic [15:0] bus,
                                        input logic [15:0] y);
    case (op)
      3'd0:    return bus + y;
      3'd1:    return bus - y;
      3'd2:    return bus & y;
      3'd3:    return bus | y;
      3'd4:    return bus ^ y;
      3'd5:    return ~bus;
      default: return bus;
    endcase
  endfunction

  function automatic logic [15:0] shift_f(input logic [15:0] a, input logic [1:0] sh);
    if (sh == 2'd1) return a << 1;
    if (sh == 2'd2) return a >> 1;
    return a;
  endfunction

  assign alu_result = alu_f(alu_control, alu_bus, alu_y_shifted);

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: a transaction timeline counted in cycles since acceptance
  // (0 = waiting for a request, 3 = response offered).
  int          m_age = 0;
  logic [2:0]  m_op = 3'd0;
  logic [15:0] m_a = 16'h0, m_b = 16'h0, m_y = 16'h0, m_z = 16'h0;
  logic [1:0]  m_sh = 2'd0;
  logic        m_err = 1'b0, m_zero = 1'b0, m_neg = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_age <= 0; m_y <= 16'h0; m_z <= 16'h0; m_err <= 1'b0; m_zero <= 1'b0; m_neg <= 1'b0;
    end else if (m_age == 0) begin
      if (req_valid) begin
        m_op <= req_op; m_a <= req_a; m_b <= req_b; m_sh <= req_shift;
        if (req_op == 3'd7 || req_shift == 2'd3) begin
          m_age <= 3; m_z <= 16'h0; m_err <= 1'b1; m_zero <= 1'b0; m_neg <= 1'b0;
        end else begin
          m_age <= 1;
        end
      end
    end else if (m_age == 1) begin
      m_y   <= shift_f(m_a, m_sh);
      m_age <= 2;
    end else if (m_age == 2) begin
      m_z    <= alu_f(m_op, m_b, m_y);
      m_zero <= (alu_f(m_op, m_b, m_y) == 16'h0);
      m_neg  <= alu_f(m_op, m_b, m_y) > 16'h7FFF;
      m_err  <= 1'b0;
      m_age  <= 3;
    end else if (rsp_ready) begin
      m_age <= 0;
    end
  end

  // Every-cycle comparison of all DUT outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("req_ready", 16'(req_ready), 16'(m_age == 0));
      check("rsp_valid", 16'(rsp_valid), 16'(m_age == 3));
      check("alu_bus", alu_bus, (m_age == 1) ? m_a : (m_age == 2) ? m_b : 16'h0);
      check("alu_control", 16'(alu_control), (m_age == 2) ? 16'(m_op) : 16'h0);
      check("alu_y_shifted", alu_y_shifted, m_y);
      check("rsp_data", rsp_data, m_z);
      check("rsp_err", 16'(rsp_err), 16'(m_err));
`ifdef ALU_SEQ_STATUS_EN
      check("rsp_zero", 16'(rsp_zero), 16'(m_zero));
      check("rsp_neg", 16'(rsp_neg), 16'(m_neg));
`endif
    end
  end

  int          lat;
  logic [15:0] s_bus1, s_bus2, s_y2;
  logic [2:0]  s_ctl1, s_ctl2;

  // Issue one request (called just after a negedge); returns at the negedge
  // where rsp_valid is first seen, with per-cycle samples captured.
  task automatic send(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                      input logic [1:0] sh);
    int n;
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_shift = sh;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      tests++; fails++;
      $display("FAIL accept_timeout: req_ready stayed %b, required 1", req_ready);
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1; s_bus1 = alu_bus; s_ctl1 = alu_control;
    s_bus2 = 16'h0; s_y2 = 16'h0; s_ctl2 = 3'd0;
    while (!rsp_valid && lat < 10) begin
      @(negedge clk);
      lat++;
      if (lat == 2) begin
        s_bus2 = alu_bus; s_y2 = alu_y_shifted; s_ctl2 = alu_control;
      end
    end
  endtask

  task automatic recv();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state.
    @(posedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    check("reset_req_ready", 16'(req_ready), 16'd1);
    check("reset_rsp_valid", 16'(rsp_valid), 16'd0);
    check("reset_rsp_data", rsp_data, 16'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Legal add.
    send(3'd0, 16'h5555, 16'hAAAA, 2'd0);
    check("add_latency", 16'(lat), 16'd3);
    check("add_loady_bus", s_bus1, 16'h5555);
    check("add_exec_bus", s_bus2, 16'hAAAA);
    check("add_exec_y", s_y2, 16'h5555);
    check("add_exec_ctl", 16'(s_ctl2), 16'd0);
    check("add_data", rsp_data, 16'hFFFF);
    check("add_err", 16'(rsp_err), 16'd0);
    recv();

    // Shift modes.
    send(3'd0, 16'h8001, 16'h0000, 2'd1);
    check("shl_exec_y", s_y2, 16'h0002);
    check("shl_data", rsp_data, 16'h0002);
    recv();
    send(3'd0, 16'h8001, 16'h0000, 2'd2);
    check("shr_exec_y", s_y2, 16'h4000);
    recv();

    // Illegal requests.
    send(3'd7, 16'h1234, 16'h5678, 2'd0);
    check("ill_op_latency", 16'(lat), 16'd1);
    check("ill_op_bus", s_bus1, 16'h0);
    check("ill_op_ctl", 16'(s_ctl1), 16'd0);
    check("ill_op_err", 16'(rsp_err), 16'd1);
    check("ill_op_data", rsp_data, 16'h0);
    recv();
    send(3'd1, 16'h1234, 16'h5678, 2'd3);
    check("ill_sh_latency", 16'(lat), 16'd1);
    check("ill_sh_err", 16'(rsp_err), 16'd1);
    recv();

    // rsp_ready high before rsp_valid; sub clears a previous error.
    rsp_ready = 1'b1;
    send(3'd1, 16'h0003, 16'h0010, 2'd0);
    check("sub_latency", 16'(lat), 16'd3);
    check("sub_exec_ctl", 16'(s_ctl2), 16'd1);
    check("sub_data", rsp_data, 16'h000D);
    check("sub_err", 16'(rsp_err), 16'd0);
    @(negedge clk);
    rsp_ready = 1'b0;
    check("sub_done_valid", 16'(rsp_valid), 16'd0);

    // Backpressure with a second request pending.
    send(3'd2, 16'hF0F0, 16'h0FF0, 2'd0);
    req_valid = 1'b1; req_op = 3'd4; req_a = 16'h00FF; req_b = 16'h0F0F; req_shift = 2'd0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid", 16'(rsp_valid), 16'd1);
      check("bp_data", rsp_data, 16'h00F0);
      check("bp_req_ready", 16'(req_ready), 16'd0);
    end
    recv();
    check("bp_idle_ready", 16'(req_ready), 16'd1);
    send(3'd4, 16'h00FF, 16'h0F0F, 2'd0);
    check("bp2_latency", 16'(lat), 16'd3);
    check("bp2_data", rsp_data, 16'h0FF0);
    recv();

    // Reset during EXEC.
    req_valid = 1'b1; req_op = 3'd0; req_a = 16'h1111; req_b = 16'h2222; req_shift = 2'd0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("pre_rst_y", alu_y_shifted, 16'h1111);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_req_ready", 16'(req_ready), 16'd1);
    check("rst_rsp_valid", 16'(rsp_valid), 16'd0);
    check("rst_bus", alu_bus, 16'h0);
    check("rst_y", alu_y_shifted, 16'h0);
    check("rst_data", rsp_data, 16'h0);
    @(negedge clk);

    // Status flags: zero then negative result.
    send(3'd0, 16'h0000, 16'h0000, 2'd0);
    check("zero_res_data", rsp_data, 16'h0000);
`ifdef ALU_SEQ_STATUS_EN
    check("st_zero_1", 16'(rsp_zero), 16'd1);
    check("st_neg_1", 16'(rsp_neg), 16'd0);
`endif
    recv();
    send(3'd0, 16'h0000, 16'h8000, 2'd0);
    check("neg_res_data", rsp_data, 16'h8000);
`ifdef ALU_SEQ_STATUS_EN
    check("st_zero_2", 16'(rsp_zero), 16'd0);
    check("st_neg_2", 16'(rsp_neg), 16'd1);
`endif
    recv();

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
